// File: rtl/alu_checker_if.sv
// alu_checker_if: vector bus between the ALU stage and its checker.
//   in_valid          qualifies the current vector
//   A, B, OP          operands and opcode as driven into the ALU
//   result, CF        ALU result and carry flag
//   gt_zero           ALU nonzero flag
// master: drives the bus (ALU side / bench). slave: the checker.
interface alu_checker_if #(
   parameter int WIDTH = 5
);
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             OP;
   logic [WIDTH-1:0] result;
   logic             CF;
   logic             gt_zero;

   modport master (
      output in_valid, A, B, OP, result, CF, gt_zero
   );

   modport slave (
      input in_valid, A, B, OP, result, CF, gt_zero
   );
endinterface

// File: rtl/alu_checker.sv
// alu_checker: self-checking monitor for the ALU stage.
// Recomputes result/CF/gt_zero for each accepted vector, counts passes and
// failures, raises a sticky error, captures the first failing vector and
// asserts done once NUM_VECTORS vectors have been checked.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   restart        one-cycle pulse: clear everything and start a new run
//   alu            vector bus (slave side)
//   pass_count     vectors that matched (saturating)
//   fail_count     vectors that mismatched (saturating)
//   mismatch       one-cycle pulse per failing vector
//   error          sticky, set on the first mismatch of a run
//   done           held high once NUM_VECTORS vectors are checked
//   fail_A/B/OP    operands/opcode of the first failing vector
//   fail_exp       expected result of the first failing vector
//
// state  | meaning
// S_IDLE | after reset/restart, waiting for the first vector
// S_RUN  | accepting vectors until NUM_VECTORS have entered the pipe
// S_DONE | all vectors checked, in_valid ignored
module alu_checker #(
   parameter int WIDTH       = 5,
   parameter int NUM_VECTORS = 3,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   alu_checker_if.slave     alu,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic             mismatch,
   output logic             error,
   output logic             done,
   output logic [WIDTH-1:0] fail_A,
   output logic [WIDTH-1:0] fail_B,
   output logic             fail_OP,
   output logic [WIDTH-1:0] fail_exp
);

   localparam int VW = $clog2(NUM_VECTORS + 1);
   localparam logic [VW-1:0]    NV_ALL  = VW'(NUM_VECTORS);
   localparam logic [VW-1:0]    NV_LAST = VW'(NUM_VECTORS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state;
   logic [VW-1:0]    acc_cnt;
   logic [VW-1:0]    chk_cnt;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_op;
   logic [WIDTH-1:0] s1_result;
   logic             s1_cf;
   logic             s1_gt;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] exp_result;
   logic             exp_cf;
   logic             exp_gt;
   logic             vec_ok;
   logic             accept;
   logic             final_chk;

   assign sum = {1'b0, s1_a} + {1'b0, s1_b};

   always_comb begin
      exp_result = (s1_a | s1_b) ^ (s1_a & s1_b);
      exp_cf     = 1'b0;
      if (s1_op) begin
         {exp_cf, exp_result} = sum;
      end
      exp_gt = (exp_result != '0);
      vec_ok = (s1_result == exp_result) && (s1_cf == exp_cf) && (s1_gt == exp_gt);
   end

   // acc_cnt caps acceptance so no vector beyond NUM_VECTORS enters stage 1
   assign accept    = alu.in_valid && (state != S_DONE) && (acc_cnt < NV_ALL);
   assign final_chk = s1_valid && (chk_cnt == NV_LAST);

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         state      <= S_IDLE;
         acc_cnt    <= '0;
         chk_cnt    <= '0;
         s1_valid   <= 1'b0;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_op      <= 1'b0;
         s1_result  <= '0;
         s1_cf      <= 1'b0;
         s1_gt      <= 1'b0;
         pass_count <= '0;
         fail_count <= '0;
         mismatch   <= 1'b0;
         error      <= 1'b0;
         done       <= 1'b0;
         fail_A     <= '0;
         fail_B     <= '0;
         fail_OP    <= 1'b0;
         fail_exp   <= '0;
      end else begin
         mismatch <= 1'b0;

         if (s1_valid) begin
            chk_cnt <= chk_cnt + 1'b1;
            if (vec_ok) begin
               if (pass_count != CNT_MAX) pass_count <= pass_count + 1'b1;
            end else begin
               if (fail_count != CNT_MAX) fail_count <= fail_count + 1'b1;
               mismatch <= 1'b1;
               error    <= 1'b1;
               if (!error) begin
                  fail_A   <= s1_a;
                  fail_B   <= s1_b;
                  fail_OP  <= s1_op;
                  fail_exp <= exp_result;
               end
            end
         end

         s1_valid <= accept;
         if (accept) begin
            acc_cnt   <= acc_cnt + 1'b1;
            s1_a      <= alu.A;
            s1_b      <= alu.B;
            s1_op     <= alu.OP;
            s1_result <= alu.result;
            s1_cf     <= alu.CF;
            s1_gt     <= alu.gt_zero;
         end

         case (state)
            S_IDLE:  if (accept) state <= S_RUN;
            S_RUN:   ;
            S_DONE:  ;
            default: state <= S_IDLE;
         endcase

         if (final_chk) begin
            state <= S_DONE;
            done  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_checker.sv
module tb_alu_checker;

   localparam int W    = 5;
   localparam int NV   = 3;
   localparam int CW   = 8;
   localparam int MOD  = 1 << W;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset;
   logic restart;
   logic [CW-1:0] pass_count, fail_count;
   logic          mismatch, error, done, fail_OP;
   logic [W-1:0]  fail_A, fail_B, fail_exp;

   always #5 clk = ~clk;

   alu_checker_if #(.WIDTH(W)) alu_bus ();

   alu_checker #(.WIDTH(W), .NUM_VECTORS(NV), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .restart    (restart),
      .alu        (alu_bus.slave),
      .pass_count (pass_count),
      .fail_count (fail_count),
      .mismatch   (mismatch),
      .error      (error),
      .done       (done),
      .fail_A     (fail_A),
      .fail_B     (fail_B),
      .fail_OP    (fail_OP),
      .fail_exp   (fail_exp)
   );

   int n_cmp = 0;
   int n_err = 0;

   // reference model state: run totals plus the one vector in flight
   int m_pass, m_fail, m_acc, m_chk;
   bit m_mis, m_err, m_done;
   int m_fa, m_fb, m_fop, m_fexp;
   bit pend_v;
   int pa, pb, pop, pr, pcf, pgt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // correct ALU behaviour: returns cf*2^(W+1) + gt*2^W + result
   function automatic int ref_out(input int a, input int b, input int op);
      int r, cf;
      if (op != 0) begin
         r  = (a + b) % MOD;
         cf = ((a + b) >= MOD) ? 1 : 0;
      end else begin
         r  = a ^ b;
         cf = 0;
      end
      return cf * (MOD * 2) + ((r != 0) ? MOD : 0) + r;
   endfunction

   task automatic model_clear();
      m_pass = 0; m_fail = 0; m_acc = 0; m_chk = 0;
      m_mis = 0; m_err = 0; m_done = 0;
      m_fa = 0; m_fb = 0; m_fop = 0; m_fexp = 0;
      pend_v = 0;
   endtask

   task automatic model_edge(input bit v, input int a, input int b, input int op,
                             input int r, input int cf, input int gt);
      int g;
      m_mis = 0;
      if (pend_v) begin
         g = ref_out(pa, pb, pop);
         if (pr == g % MOD && pcf == g / (MOD * 2) && pgt == (g / MOD) % 2) begin
            if (m_pass < CMAX) m_pass++;
         end else begin
            if (m_fail < CMAX) m_fail++;
            m_mis = 1;
            if (!m_err) begin
               m_fa = pa; m_fb = pb; m_fop = pop; m_fexp = g % MOD;
            end
            m_err = 1;
         end
         m_chk++;
         if (m_chk == NV) m_done = 1;
      end
      pend_v = v && (m_acc < NV);
      if (pend_v) begin
         m_acc++;
         pa = a; pb = b; pop = op; pr = r; pcf = cf; pgt = gt;
      end
   endtask

   task automatic compare_all();
      check("pass_count", 32'(pass_count), m_pass);
      check("fail_count", 32'(fail_count), m_fail);
      check("mismatch",   32'(mismatch),   32'(m_mis));
      check("error",      32'(error),      32'(m_err));
      check("done",       32'(done),       32'(m_done));
      check("fail_A",     32'(fail_A),     m_fa);
      check("fail_B",     32'(fail_B),     m_fb);
      check("fail_OP",    32'(fail_OP),    m_fop);
      check("fail_exp",   32'(fail_exp),   m_fexp);
   endtask

   task automatic step(input bit v, input int a, input int b, input int op,
                       input int r, input int cf, input int gt,
                       input bit rs, input bit rst);
      logic [31:0] av, bv, rv;
      av = a; bv = b; rv = r;
      alu_bus.in_valid = v;
      alu_bus.A        = av[W-1:0];
      alu_bus.B        = bv[W-1:0];
      alu_bus.OP       = (op != 0);
      alu_bus.result   = rv[W-1:0];
      alu_bus.CF       = (cf != 0);
      alu_bus.gt_zero  = (gt != 0);
      restart          = rs;
      reset            = rst;
      @(posedge clk);
      if (rst || rs) model_clear();
      else model_edge(v, a, b, op, r, cf, gt);
      #1;
      compare_all();
   endtask

   // drive a vector with the correct ALU outputs XOR-ed with the given deltas
   task automatic vecx(input int a, input int b, input int op,
                       input int dr, input int dcf, input int dgt,
                       input bit rs = 1'b0, input bit rst = 1'b0);
      int g;
      g = ref_out(a, b, op);
      step(1'b1, a, b, op, (g % MOD) ^ dr, (g / (MOD * 2)) ^ dcf, ((g / MOD) % 2) ^ dgt, rs, rst);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic do_restart();
      step(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
   endtask

   initial begin
      model_clear();
      step(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);

      // clean three-vector run
      vecx(21, 27, 0, 0, 0, 0);
      vecx(13, 3, 1, 0, 0, 0);
      vecx(31, 1, 1, 0, 0, 0);
      idle(2);
      check("t1_pass", 32'(pass_count), 3);
      check("t1_done", 32'(done), 1);

      // wrong result on vector 2
      do_restart();
      vecx(21, 27, 0, 0, 0, 0);
      vecx(13, 3, 1, 1, 0, 0);
      vecx(31, 1, 1, 0, 0, 0);
      idle(2);
      check("t2_fail", 32'(fail_count), 1);
      check("t2_fexp", 32'(fail_exp), 16);

      // flag errors on vector 3
      do_restart();
      vecx(21, 27, 0, 0, 0, 0);
      vecx(13, 3, 1, 0, 0, 0);
      vecx(31, 1, 1, 0, 1, 0);
      idle(2);
      do_restart();
      vecx(21, 27, 0, 0, 0, 0);
      vecx(13, 3, 1, 0, 0, 0);
      vecx(31, 1, 1, 0, 0, 1);
      idle(2);
      do_restart();
      vecx(21, 27, 0, 0, 0, 0);
      vecx(13, 3, 1, 1, 0, 0);
      vecx(31, 1, 1, 0, 1, 0);
      idle(2);
      check("t3_keepA", 32'(fail_A), 13);

      // gapped valid, then valid held after done
      do_restart();
      vecx(21, 27, 0, 0, 0, 0);
      idle(1);
      vecx(13, 3, 1, 0, 0, 0);
      idle(1);
      vecx(31, 1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) vecx(i, 7, 1, 0, 0, 0);
      check("t4_pass", 32'(pass_count), 3);

      // restart coincident with vector 2
      do_restart();
      vecx(21, 27, 0, 0, 0, 0);
      vecx(13, 3, 1, 0, 0, 0, 1'b1);
      idle(1);
      vecx(21, 27, 0, 0, 0, 0);
      vecx(13, 3, 1, 0, 0, 0);
      vecx(31, 1, 1, 0, 0, 0);
      idle(2);

      // reset while vector 2 sits in stage 1
      do_restart();
      vecx(21, 27, 0, 1, 0, 0);
      vecx(13, 3, 1, 0, 0, 0);
      vecx(31, 1, 1, 0, 0, 0, 1'b0, 1'b1);
      idle(3);
      check("t6_pass", 32'(pass_count), 0);

      // randomized runs
      for (int run = 0; run < 40; run++) begin
         if ($urandom_range(0, 9) == 0)
            step(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
         else
            do_restart();
         for (int c = 0; c < 8; c++) begin
            int sel, a, b, op;
            sel = $urandom_range(0, 19);
            a   = $urandom_range(0, MOD - 1);
            b   = $urandom_range(0, MOD - 1);
            op  = $urandom_range(0, 1);
            if (sel < 5)
               idle(1);
            else if (sel == 5)
               vecx(a, b, op, 0, 0, 0, 1'b1);
            else if (sel < 10)
               vecx(a, b, op, $urandom_range(0, MOD - 1), $urandom_range(0, 1), $urandom_range(0, 1));
            else
               vecx(a, b, op, 0, 0, 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
